button_ctrl: RTL and testbench

BUTTON_CTRL -- requirements
Module: button_ctrl

---
 rtl/button_ctrl.sv | 166 ++++++++++++++++
 tb/tb_button_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// button_ctrl: debounced left/right move keys with auto-repeat.
// Each raw key is synchronized, debounced into a stable level (held),
// and drives a small FSM that emits a first move strobe followed by
// auto-repeat strobes while the key stays held. A strobe is only
// forwarded to its output when the opposite key is released, so the
// game logic never sees both directions at once.
module button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 20,
    parameter int unsigned REPEAT_PERIOD   = 2
) (
    input  logic       button_clk,
    input  logic       rst_n,
    input  logic       key_left_n,
    input  logic       key_right_n,
    output logic       button_left,
    output logic       button_right,
    output logic [1:0] held
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_DELAY,
        S_REPEAT
    } state_t;

    localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] RPT_DELAY  = 16'(REPEAT_DELAY);
    localparam logic [15:0] RPT_PERIOD = 16'(REPEAT_PERIOD);

    // Index 0 is the left key, index 1 the right key.
    logic [1:0] w_key_n;
    logic [1:0] w_db;
    logic [1:0] w_strobe;
    logic       r_button_left;
    logic       r_button_right;

    assign w_key_n = {key_right_n, key_left_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic        r_sync1;
        logic        r_sync2;
        logic        r_db;
        logic [15:0] r_db_cnt;
        state_t      r_state;
        state_t      w_state_next;
        logic [15:0] r_timer;
        logic [15:0] w_timer_next;
        logic [15:0] w_timer_inc;
        logic        w_strobe_next;
        logic        w_s_pressed;

        // Two-flop synchronizer for the asynchronous raw key; resets to released.
        always_ff @(posedge button_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                // NOTE: non-blocking assignments let r_sync2 take the old r_sync1,
                // giving a true two-stage shift instead of a single flop.
                r_sync1 <= w_key_n[k];
                r_sync2 <= r_sync1;
            end
        end

        assign w_s_pressed = ~r_sync2;

        // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge button_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_db     <= 1'b0;
                r_db_cnt <= '0;
            end else if (w_s_pressed != r_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db     <= ~r_db;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 16'd1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end

        assign w_timer_inc = r_timer + 16'd1;

        // Repeat FSM next-state logic; w_strobe_next is the strobe for the coming cycle.
        always_comb begin
            // NOTE: every output gets a default first so no path can infer a latch.
            w_state_next  = r_state;
            w_timer_next  = r_timer;
            w_strobe_next = 1'b0;
            if (!r_db) begin
                // Release wins from any state and never emits a strobe.
                w_state_next = S_IDLE;
                w_timer_next = '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        w_state_next  = S_FIRST;
                        w_strobe_next = 1'b1;
                        w_timer_next  = '0;
                    end
                    S_FIRST: begin
                        w_state_next = S_DELAY;
                        w_timer_next = 16'd1;
                    end
                    S_DELAY: begin
                        // >= keeps a delay of 1 from stalling, since FIRST preloads 1.
                        if (w_timer_inc >= RPT_DELAY) begin
                            w_state_next  = S_REPEAT;
                            w_strobe_next = 1'b1;
                            w_timer_next  = '0;
                        end else begin
                            w_timer_next = w_timer_inc;
                        end
                    end
                    S_REPEAT: begin
                        if (w_timer_inc >= RPT_PERIOD) begin
                            w_strobe_next = 1'b1;
                            w_timer_next  = '0;
                        end else begin
                            w_timer_next = w_timer_inc;
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_timer_next = '0;
                    end
                endcase
            end
        end

        // Repeat FSM state and timer registers.
        always_ff @(posedge button_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_timer <= '0;
            end else begin
                r_state <= w_state_next;
                r_timer <= w_timer_next;
            end
        end

        assign w_db[k]     = r_db;
        assign w_strobe[k] = w_strobe_next;
    end

    // Registered active-low strobes; a strobe needs the opposite key released,
    // and it needs its own key pressed, so both outputs can never be low together.
    always_ff @(posedge button_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_button_left  <= 1'b1;
            r_button_right <= 1'b1;
        end else begin
            r_button_left  <= ~(w_strobe[0] & ~w_db[1]);
            r_button_right <= ~(w_strobe[1] & ~w_db[0]);
        end
    end

    assign button_left  = r_button_left;
    assign button_right = r_button_right;
    assign held         = w_db;

endmodule

// File: tb/tb_button_ctrl.sv
// Testbench for button_ctrl: directed scenarios with edge-accurate
// expectations, plus a randomized run against a behavioural model.
module tb_button_ctrl;

    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 2;

    logic       button_clk;
    logic       rst_n;
    logic       key_left_n;
    logic       key_right_n;
    logic       button_left;
    logic       button_right;
    logic [1:0] held;

    logic       fk_left_n;
    logic       fk_right_n;
    logic       f_left;
    logic       f_right;
    logic [1:0] f_held;

    int n_tests = 0;
    int n_fail  = 0;

    button_ctrl u_dut (
        .button_clk  (button_clk),
        .rst_n       (rst_n),
        .key_left_n  (key_left_n),
        .key_right_n (key_right_n),
        .button_left (button_left),
        .button_right(button_right),
        .held        (held)
    );

    button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (3),
        .REPEAT_PERIOD  (1)
    ) u_fast (
        .button_clk  (button_clk),
        .rst_n       (rst_n),
        .key_left_n  (fk_left_n),
        .key_right_n (fk_right_n),
        .button_left (f_left),
        .button_right(f_right),
        .held        (f_held)
    );

    initial button_clk = 1'b0;
    always #5 button_clk = ~button_clk;

    // Behavioural model of the default instance. Debounce is a run-length of
    // disagreeing samples; strobe timing is an age count since the press was
    // accepted: strobe at age 0, at RD, then every RP cycles.
    logic [1:0] m_keys_n;
    logic [1:0] m_sync1;
    logic [1:0] m_s;
    logic [1:0] m_db;
    logic [1:0] m_active;
    logic [1:0] m_btn;
    logic [1:0] m_stb;
    int         m_run    [2];
    int         m_age    [2];
    int         m_age_nx [2];

    assign m_keys_n = {key_right_n, key_left_n};

    always_comb begin
        m_stb = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_age_nx[i] = m_active[i] ? m_age[i] + 1 : 0;
            m_stb[i] = m_db[i] && (m_age_nx[i] == 0 ||
                       (m_age_nx[i] >= RD && ((m_age_nx[i] - RD) % RP) == 0));
        end
    end

    always @(posedge button_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync1  <= 2'b11;
            m_s      <= 2'b11;
            m_db     <= 2'b00;
            m_active <= 2'b00;
            m_btn    <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                m_run[i] <= 0;
                m_age[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_age[i]    <= m_age_nx[i];
                m_active[i] <= m_db[i];
                if ((!m_s[i]) != m_db[i]) begin
                    if (m_run[i] + 1 == DC) begin
                        m_db[i]  <= !m_db[i];
                        m_run[i] <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
                m_s[i]     <= m_sync1[i];
                m_sync1[i] <= m_keys_n[i];
            end
            m_btn[0] <= !(m_stb[0] && !m_db[1]);
            m_btn[1] <= !(m_stb[1] && !m_db[0]);
        end
    end

    task automatic tick();
        @(posedge button_clk);
        @(negedge button_clk);
    endtask

    task automatic settle();
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        fk_left_n   = 1'b1;
        fk_right_n  = 1'b1;
        for (int i = 0; i < 15; i++) tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (held !== 2'b00 || button_left !== 1'b1 || button_right !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_default: held=%b l=%b r=%b want held=00 l=1 r=1",
                     held, button_left, button_right);
        end
        n_tests++;
        if (f_held !== 2'b00 || f_left !== 1'b1 || f_right !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fast: held=%b l=%b r=%b want held=00 l=1 r=1",
                     f_held, f_left, f_right);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (held !== 2'b00 || button_left !== 1'b1 || button_right !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_idle cyc %0d: held=%b l=%b r=%b want 00 1 1",
                         i, held, button_left, button_right);
            end
        end
    endtask

    task automatic test_single_press();
        logic       exp_l;
        logic [1:0] exp_h;
        for (int e = 0; e <= 34; e++) begin
            key_left_n = 1'b0;
            tick();
            exp_l = !(e == 6 || (e >= 26 && e % 2 == 0));
            exp_h = {1'b0, e >= 5};
            n_tests++;
            if (button_left !== exp_l || button_right !== 1'b1 || held !== exp_h) begin
                n_fail++;
                $display("FAIL single_press edge %0d: l=%b r=%b held=%b want l=%b r=1 held=%b",
                         e, button_left, button_right, held, exp_l, exp_h);
            end
        end
        settle();
    endtask

    task automatic test_bounce();
        for (int e = 0; e <= 15; e++) begin
            key_right_n = (e < 3 || (e >= 4 && e < 7)) ? 1'b0 : 1'b1;
            tick();
            n_tests++;
            if (held !== 2'b00 || button_right !== 1'b1 || button_left !== 1'b1) begin
                n_fail++;
                $display("FAIL bounce edge %0d: held=%b r=%b l=%b want held=00 r=1 l=1",
                         e, held, button_right, button_left);
            end
        end
        settle();
    endtask

    task automatic test_release_delay();
        logic       exp_l;
        logic [1:0] exp_h;
        for (int e = 0; e <= 30; e++) begin
            key_left_n = (e >= 16);
            tick();
            exp_l = !(e == 6);
            exp_h = {1'b0, (e >= 5 && e < 21)};
            n_tests++;
            if (button_left !== exp_l || held !== exp_h) begin
                n_fail++;
                $display("FAIL release_delay edge %0d: l=%b held=%b want l=%b held=%b",
                         e, button_left, held, exp_l, exp_h);
            end
        end
        // A fresh press must restart from IDLE with full latency.
        for (int e = 0; e <= 8; e++) begin
            key_left_n = 1'b0;
            tick();
            exp_l = !(e == 6);
            n_tests++;
            if (button_left !== exp_l) begin
                n_fail++;
                $display("FAIL repress edge %0d: l=%b want %b", e, button_left, exp_l);
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        logic       exp_l;
        logic       exp_r;
        logic [1:0] exp_h;
        for (int e = 0; e <= 55; e++) begin
            key_left_n  = (e >= 41);
            key_right_n = (e < 10);
            tick();
            exp_l = !(e == 6);
            exp_r = !(e >= 48 && e % 2 == 0);
            exp_h = {e >= 15, (e >= 5 && e < 46)};
            n_tests++;
            if (button_left !== exp_l || button_right !== exp_r || held !== exp_h) begin
                n_fail++;
                $display("FAIL simultaneous edge %0d: l=%b r=%b held=%b want l=%b r=%b held=%b",
                         e, button_left, button_right, held, exp_l, exp_r, exp_h);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid();
        key_left_n = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (held !== 2'b00 || button_left !== 1'b1 || button_right !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_async: held=%b l=%b r=%b want 00 1 1",
                     held, button_left, button_right);
        end
        @(negedge button_clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            n_tests++;
            if (button_left !== !(e == 6) || held !== {1'b0, e >= 5}) begin
                n_fail++;
                $display("FAIL reset_mid_repress edge %0d: l=%b held=%b want l=%b held=%b",
                         e, button_left, held, !(e == 6), {1'b0, e >= 5});
            end
        end
        settle();
    endtask

    task automatic test_fast_repeat();
        logic       exp_l;
        logic [1:0] exp_h;
        for (int e = 0; e <= 30; e++) begin
            fk_left_n = (e >= 21);
            tick();
            exp_l = !(e == 6 || (e >= 9 && e <= 26));
            exp_h = {1'b0, (e >= 5 && e < 26)};
            n_tests++;
            if (f_left !== exp_l || f_right !== 1'b1 || f_held !== exp_h) begin
                n_fail++;
                $display("FAIL fast_repeat edge %0d: l=%b r=%b held=%b want l=%b r=1 held=%b",
                         e, f_left, f_right, f_held, exp_l, exp_h);
            end
        end
        settle();
    endtask

    task automatic test_random();
        int dur_l = 0;
        int dur_r = 0;
        for (int c = 0; c < 1500; c++) begin
            if (dur_l == 0) begin
                key_left_n = 1'($urandom_range(0, 1));
                dur_l = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 5))
                                                   : int'($urandom_range(6, 60));
            end
            if (dur_r == 0) begin
                key_right_n = 1'($urandom_range(0, 1));
                dur_r = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 5))
                                                   : int'($urandom_range(6, 60));
            end
            dur_l--;
            dur_r--;
            tick();
            n_tests++;
            if (held !== m_db || button_left !== m_btn[0] || button_right !== m_btn[1]) begin
                n_fail++;
                $display("FAIL random cyc %0d: held=%b l=%b r=%b want held=%b l=%b r=%b",
                         c, held, button_left, button_right, m_db, m_btn[0], m_btn[1]);
            end
            n_tests++;
            if (!button_left && !button_right) begin
                n_fail++;
                $display("FAIL random_exclusive cyc %0d: l=%b r=%b want not both 0",
                         c, button_left, button_right);
            end
        end
        settle();
    endtask

    initial begin
        rst_n       = 1'b0;
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        fk_left_n   = 1'b1;
        fk_right_n  = 1'b1;
        test_reset();
        test_single_press();
        test_bounce();
        test_release_delay();
        test_simultaneous();
        test_reset_mid();
        test_fast_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
